// File: rtl/aes_spi_pkg.sv
// Shared state encoding and width helpers for the AES core SPI master.
package aes_spi_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SEND_DATA,
        SEND_KEY,
        WAIT,
        RD_LEAD,
        RECV,
        DONE
    } state_t;

    function automatic int blk_w(input int nb);
        return WORD_W * nb;
    endfunction

    function automatic int key_w(input int nk);
        return WORD_W * nk;
    endfunction

    // One spare bit above log2 of the longest shift phase.
    function automatic int cnt_w(input int nb, input int nk);
        int longest;
        longest = (nb > nk) ? WORD_W * nb : WORD_W * nk;
        return $clog2(longest) + 1;
    endfunction

endpackage

// File: rtl/aes_spi_shifter.sv
// Generic LSB-first shift register: parallel load, then shift right with the
// serial input entering at the MSB; bit 0 is the serial output.
module aes_spi_shifter #(
    parameter int W = 128
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_shift,
    input  logic         i_sin,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Load has priority over shift.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= {W{1'b0}};
        end else if (i_load) begin
            r_q <= i_load_val;
        end else if (i_shift) begin
            r_q <= {i_sin, r_q[W-1:1]};
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/aes_spi_master.sv
// Serial bridge to the AES Encrypt/Decrypt core: ships data then key LSB-first,
// waits for finished, reads the result back. AES_SPI_TIMEOUT_EN adds a WAIT watchdog.
module aes_spi_master
    import aes_spi_pkg::*;
#(
    parameter int Nb             = 4,
    parameter int Nk             = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [blk_w(Nb)-1:0]  data_in,
    input  logic [key_w(Nk)-1:0]  key_in,
    output logic                  busy,
    output logic                  done,
    output logic [blk_w(Nb)-1:0]  data_out,
    output logic                  err,
    output logic                  core_cs,
    output logic                  core_miso,
    input  logic                  core_mosi,
    input  logic                  core_finished
);

    localparam int BLK   = blk_w(Nb);
    localparam int KEY   = key_w(Nk);
    localparam int CNT_W = cnt_w(Nb, Nk);
    localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLK - 1);
    localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY - 1);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_accept;
    logic               w_tx_shift;
    logic               w_rx_shift;
    logic               w_timeout;
    logic               w_timed_out;
    logic [BLK+KEY-1:0] w_tx_q;
    logic [BLK-1:0]     w_rx_q;
    logic               w_unused_tx;
    logic               r_busy;
    logic               r_done;
    logic               r_cs;
    logic               r_miso;
    logic [BLK-1:0]     r_data_out;

    assign w_accept    = (r_state == IDLE) && start;
    assign w_tx_shift  = (r_state == SEND_DATA) || (r_state == SEND_KEY);
    assign w_rx_shift  = (r_state == RECV);
    assign w_unused_tx = ^w_tx_q[BLK+KEY-1:1];

`ifdef AES_SPI_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] r_wdog;
    logic            r_timed_out;
    logic            r_err;

    assign w_timeout   = (r_state == WAIT) && !core_finished && (r_wdog == WD_LAST);
    assign w_timed_out = r_timed_out;
    assign err         = r_err;

    // Watchdog runs only while parked in WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog <= {WD_W{1'b0}};
        end else if (r_state == WAIT) begin
            r_wdog <= r_wdog + WD_W'(1);
        end else begin
            r_wdog <= {WD_W{1'b0}};
        end
    end

    // Timeout is remembered until DONE publishes it; err then holds until the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timed_out <= 1'b0;
            r_err       <= 1'b0;
        end else if (w_accept) begin
            r_timed_out <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_timed_out <= r_timed_out | w_timeout;
            r_err       <= (r_state == DONE) ? r_timed_out : r_err;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;

    assign w_timeout   = 1'b0;
    assign w_timed_out = 1'b0;
    assign err         = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; WAIT ignores the finished value sampled on its entry edge by construction.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (start) w_next = LEAD; else w_next = IDLE;
            LEAD:      w_next = SEND_DATA;
            SEND_DATA: if (r_cnt == BLK_LAST) w_next = SEND_KEY; else w_next = SEND_DATA;
            SEND_KEY:  if (r_cnt == KEY_LAST) w_next = WAIT; else w_next = SEND_KEY;
            WAIT: begin
                if (core_finished)  w_next = RD_LEAD;
                else if (w_timeout) w_next = DONE;
                else                w_next = WAIT;
            end
            RD_LEAD:   w_next = RECV;
            RECV:      if (r_cnt == BLK_LAST) w_next = DONE; else w_next = RECV;
            DONE:      w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // Bit counter restarts on every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_next != r_state) begin
            r_cnt <= {CNT_W{1'b0}};
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    aes_spi_shifter #(.W(BLK + KEY)) u_tx (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (w_accept),
        .i_load_val ({key_in, data_in}),
        .i_shift    (w_tx_shift),
        .i_sin      (1'b0),
        .o_q        (w_tx_q)
    );

    aes_spi_shifter #(.W(BLK)) u_rx (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (w_accept),
        .i_load_val ({BLK{1'b0}}),
        .i_shift    (w_rx_shift),
        .i_sin      (core_mosi),
        .o_q        (w_rx_q)
    );

    // Interface outputs are registered from the current state, so they trail it by one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cs       <= 1'b0;
            r_miso     <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_data_out <= {BLK{1'b0}};
        end else begin
            r_cs   <= (r_state == LEAD) || w_tx_shift || (r_state == RD_LEAD) || w_rx_shift;
            r_miso <= w_tx_shift ? w_tx_q[0] : 1'b0;
            r_done <= (r_state == DONE);
            if (w_accept) begin
                r_busy <= 1'b1;
            end else if (r_state == DONE) begin
                r_busy <= 1'b0;
            end else begin
                r_busy <= r_busy;
            end
            if ((r_state == DONE) && !w_timed_out) begin
                r_data_out <= w_rx_q;
            end else begin
                r_data_out <= r_data_out;
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign data_out  = r_data_out;
    assign core_cs   = r_cs;
    assign core_miso = r_miso;

endmodule
